// File: rtl/alu_sequencer.sv
// Sequencer that issues {src, dst, op} tuples to a multi-cycle ALU over a
// start/done handshake and keeps the result in a chainable accumulator.
module alu_sequencer #(
   parameter int W       = 16,
   parameter int OPW     = 4,
   parameter int TIMEOUT = 15
) (
   input  logic           Clock,
   input  logic           Reset,
   input  logic           clear,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_src,
   input  logic [W-1:0]   in_dst,
   input  logic [OPW-1:0] in_op,
   input  logic           in_chain,
   output logic           alu_start,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   output logic [OPW-1:0] alu_op,
   input  logic           alu_done,
   input  logic [W-1:0]   alu_result,
   input  logic           alu_err,
   output logic [W-1:0]   acc,
   output logic           acc_valid,
   output logic           error,
   output logic           busy,
   output logic [7:0]     op_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_ERR
   } state_t;

   // Last WAIT cycle index: the timeout fires on the TIMEOUT-th edge spent in WAIT.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] timer;

   assign in_ready = (state == S_IDLE);
   assign busy     = (state == S_ISSUE) || (state == S_WAIT);

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state     <= S_IDLE;
         timer     <= '0;
         acc       <= '0;
         acc_valid <= 1'b0;
         error     <= 1'b0;
         op_count  <= '0;
         alu_start <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
      end else if (clear) begin
         // op_count and the latched ALU operands deliberately survive a clear.
         state     <= S_IDLE;
         timer     <= '0;
         acc       <= '0;
         acc_valid <= 1'b0;
         error     <= 1'b0;
         alu_start <= 1'b0;
      end else begin
         alu_start <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  alu_a     <= (in_chain && acc_valid) ? acc : in_src;
                  alu_b     <= in_dst;
                  alu_op    <= in_op;
                  alu_start <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               timer <= '0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               // A done pulse takes priority over a timeout landing on the same edge.
               if (alu_done) begin
                  if (alu_err) begin
                     error <= 1'b1;
                     state <= S_ERR;
                  end else begin
                     acc       <= alu_result;
                     acc_valid <= 1'b1;
                     op_count  <= op_count + 8'd1;
                     state     <= S_IDLE;
                  end
               end else if (timer == TIMER_LAST) begin
                  error <= 1'b1;
                  state <= S_ERR;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_ERR: begin
               state <= S_ERR;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: behavioural add/sub ALU with programmable
// latency, error injection and a silent mode for timeout checks.
module tb_alu_sequencer;

   localparam int W       = 16;
   localparam int OPW     = 4;
   localparam int TIMEOUT = 15;

   logic           Clock = 1'b0;
   logic           Reset;
   logic           clear;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_src;
   logic [W-1:0]   in_dst;
   logic [OPW-1:0] in_op;
   logic           in_chain;
   logic           alu_start;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [OPW-1:0] alu_op;
   logic           alu_done;
   logic [W-1:0]   alu_result;
   logic           alu_err;
   logic [W-1:0]   acc;
   logic           acc_valid;
   logic           error;
   logic           busy;
   logic [7:0]     op_count;

   int checks = 0;
   int errors = 0;

   // ALU model controls: mode 0 = normal, 1 = answer with alu_err, 2 = never answer
   int         alu_lat  = 2;
   int         alu_mode = 0;
   logic       inject   = 1'b0;
   logic [W-1:0] inject_val = '0;

   always #5 Clock = ~Clock;

   alu_sequencer #(.W(W), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_src     (in_src),
      .in_dst     (in_dst),
      .in_op      (in_op),
      .in_chain   (in_chain),
      .alu_start  (alu_start),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_done   (alu_done),
      .alu_result (alu_result),
      .alu_err    (alu_err),
      .acc        (acc),
      .acc_valid  (acc_valid),
      .error      (error),
      .busy       (busy),
      .op_count   (op_count)
   );

   // ALU model runs 2 time units after each rising edge; the main sequence
   // drives and samples on falling edges, so the two never race.
   initial begin
      int           cnt;
      logic [W-1:0] ra, rb;
      logic [OPW-1:0] rop;
      cnt        = 0;
      alu_done   = 1'b0;
      alu_err    = 1'b0;
      alu_result = '0;
      forever begin
         @(posedge Clock);
         #2;
         alu_done = 1'b0;
         alu_err  = 1'b0;
         if (inject) begin
            alu_done   = 1'b1;
            alu_result = inject_val;
            inject     = 1'b0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               alu_done   = 1'b1;
               alu_err    = (alu_mode == 1);
               alu_result = (rop == 4'd1) ? ra - rb : ra + rb;
            end
         end
         if (alu_start && alu_mode != 2) begin
            cnt = alu_lat;
            ra  = alu_a;
            rb  = alu_b;
            rop = alu_op;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // Offer one tuple at the current falling edge; returns one cycle later (ISSUE).
   task automatic issue(input logic [W-1:0] src, input logic [W-1:0] dst,
                        input logic [OPW-1:0] op, input logic chain);
      in_valid = 1'b1;
      in_src   = src;
      in_dst   = dst;
      in_op    = op;
      in_chain = chain;
      step(1);
      in_valid = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!in_ready && n < 100) begin
         step(1);
         n++;
      end
      check(tag, 32'(in_ready), 32'd1);
   endtask

   task automatic wait_error(input string tag);
      int n = 0;
      while (!error && n < 100) begin
         step(1);
         n++;
      end
      check(tag, 32'(error), 32'd1);
   endtask

   initial begin
      int xfers;
      int starts;
      int cyc;

      Reset    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_src   = '0;
      in_dst   = '0;
      in_op    = '0;
      in_chain = 1'b0;
      step(2);
      Reset = 1'b0;
      step(1);

      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_acc",       32'(acc),       32'd0);
      check("rst_acc_valid", 32'(acc_valid), 32'd0);
      check("rst_error",     32'(error),     32'd0);
      check("rst_op_count",  32'(op_count),  32'd0);
      check("rst_alu_start", 32'(alu_start), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);

      // 1: 56 + 37 with latency 2
      alu_lat = 2;
      issue(16'd56, 16'd37, 4'd0, 1'b0);
      check("t1_start_hi", 32'(alu_start), 32'd1);
      check("t1_busy",     32'(busy),      32'd1);
      check("t1_ready_lo", 32'(in_ready),  32'd0);
      check("t1_alu_a",    32'(alu_a),     32'd56);
      check("t1_alu_b",    32'(alu_b),     32'd37);
      step(1);
      check("t1_start_lo", 32'(alu_start), 32'd0);
      step(1);
      check("t1_wait_busy", 32'(busy), 32'd1);
      step(1);
      check("t1_ready_back", 32'(in_ready), 32'd1);
      check("t1_acc",        32'(acc),       32'd93);
      check("t1_acc_valid",  32'(acc_valid), 32'd1);
      check("t1_op_count",   32'(op_count),  32'd1);

      // 2: chained subtract, 93 - 49
      issue(16'd1000, 16'd49, 4'd1, 1'b1);
      check("t2_alu_a", 32'(alu_a),  32'd93);
      check("t2_alu_op", 32'(alu_op), 32'd1);
      wait_ready("t2_ready");
      check("t2_acc",      32'(acc),      32'd44);
      check("t2_op_count", 32'(op_count), 32'd2);

      // 3: ALU error, then clear while a tuple is held on the input
      alu_mode = 1;
      issue(16'd1, 16'd2, 4'd0, 1'b0);
      wait_error("t3_error");
      check("t3_acc_kept", 32'(acc), 32'd44);
      in_valid = 1'b1;
      in_src   = 16'd9;
      step(2);
      check("t3_ready_lo_err", 32'(in_ready), 32'd0);
      check("t3_busy_lo_err",  32'(busy),     32'd0);
      clear = 1'b1;
      step(1);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t3_clr_acc",       32'(acc),       32'd0);
      check("t3_clr_acc_valid", 32'(acc_valid), 32'd0);
      check("t3_clr_error",     32'(error),     32'd0);
      check("t3_clr_ready",     32'(in_ready),  32'd1);
      check("t3_clr_no_start",  32'(alu_start), 32'd0);
      check("t3_op_count_kept", 32'(op_count),  32'd2);
      alu_mode = 0;

      // 4: silent ALU, timeout exactly TIMEOUT edges after entering WAIT
      alu_mode = 2;
      issue(16'd5, 16'd6, 4'd0, 1'b0);
      step(TIMEOUT);
      check("t4_no_err_early", 32'(error), 32'd0);
      step(1);
      check("t4_err_on_time", 32'(error), 32'd1);
      inject_val = 16'd999;
      inject     = 1'b1;
      step(3);
      check("t4_late_done_acc",   32'(acc),       32'd0);
      check("t4_late_done_valid", 32'(acc_valid), 32'd0);
      check("t4_err_sticky",      32'(error),     32'd1);
      clear = 1'b1;
      step(1);
      clear    = 1'b0;
      alu_mode = 0;
      check("t4_clr_error", 32'(error), 32'd0);

      // 5: reset during WAIT, ALU answers afterwards
      alu_lat = 3;
      issue(16'd10, 16'd20, 4'd0, 1'b0);
      step(1);
      check("t5_in_wait", 32'(busy), 32'd1);
      Reset = 1'b1;
      step(1);
      Reset = 1'b0;
      step(3);
      check("t5_acc",       32'(acc),       32'd0);
      check("t5_acc_valid", 32'(acc_valid), 32'd0);
      check("t5_op_count",  32'(op_count),  32'd0);
      check("t5_error",     32'(error),     32'd0);
      check("t5_alu_a",     32'(alu_a),     32'd0);
      check("t5_alu_b",     32'(alu_b),     32'd0);
      check("t5_ready",     32'(in_ready),  32'd1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_src   = 16'd77;
      step(1);
      clear    = 1'b0;
      in_valid = 1'b0;
      check("t5_clr_no_xfer_start", 32'(alu_start), 32'd0);
      check("t5_clr_no_xfer_busy",  32'(busy),      32'd0);
      check("t5_clr_no_xfer_a",     32'(alu_a),     32'd0);

      // chain request with an empty accumulator falls back to in_src
      alu_lat = 1;
      issue(16'd7, 16'd8, 4'd0, 1'b1);
      check("t5_chain_empty_a", 32'(alu_a), 32'd7);
      wait_ready("t5_chain_ready");
      check("t5_chain_acc", 32'(acc), 32'd15);

      // 6: 256 back-to-back adds with in_valid held high
      Reset = 1'b1;
      step(1);
      Reset    = 1'b0;
      xfers    = 0;
      starts   = 0;
      cyc      = 0;
      in_dst   = 16'd1;
      in_op    = 4'd0;
      in_chain = 1'b0;
      in_valid = 1'b1;
      while (xfers < 256 && cyc < 5000) begin
         if (in_ready) begin
            in_src = 16'(xfers);
            xfers++;
         end
         step(1);
         cyc++;
         if (alu_start) starts++;
      end
      in_valid = 1'b0;
      while (!in_ready && cyc < 5000) begin
         step(1);
         cyc++;
         if (alu_start) starts++;
      end
      check("t6_transfers",  32'(xfers),     32'd256);
      check("t6_starts",     32'(starts),    32'd256);
      check("t6_ready",      32'(in_ready),  32'd1);
      check("t6_op_wrap",    32'(op_count),  32'd0);
      check("t6_last_acc",   32'(acc),       32'd256);
      check("t6_acc_valid",  32'(acc_valid), 32'd1);
      step(3);
      check("t6_no_extra_start", 32'(op_count), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
